seg_scan_ctrl: RTL



---
 rtl/seg_scan_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Seven-segment display controller: latches one debug channel and drives it as a
// registered static segment bus and as a time-multiplexed anode/segment scan.
module seg_scan_ctrl #(
  parameter int NDIGITS  = 8,
  parameter int NCH      = 2,
  parameter int SCAN_DIV = 50000,
  parameter int SELW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NCH*4*NDIGITS-1:0]  data_in,
  input  logic [SELW-1:0]           ch_sel,
  input  logic                      load,
  input  logic                      freeze,
  input  logic                      blank_lz,
  input  logic [NDIGITS-1:0]        dp_mask,
  output logic [8*NDIGITS-1:0]      seg_all,
  output logic [NDIGITS-1:0]        an,
  output logic [7:0]                seg_scan,
  output logic                      frame_done,
  output logic                      sel_err
);

  localparam int W    = 4 * NDIGITS;
  localparam int DIVW = $clog2(SCAN_DIV);
  localparam int IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  logic [W-1:0]         hold;
  logic [W-1:0]         sel_data;
  logic                 sel_ok;
  logic [NDIGITS-1:0]   nz_from;
  logic                 nz_run;
  logic [7:0]           glyph;
  logic [8*NDIGITS-1:0] dec_flat;
  logic [DIVW-1:0]      div;
  logic [IDXW-1:0]      idx;
  logic                 div_wrap;
  logic                 idx_last;

  function automatic logic [7:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 8'hC0;
      4'h1: hex7 = 8'hF9;
      4'h2: hex7 = 8'hA4;
      4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;
      4'h5: hex7 = 8'h92;
      4'h6: hex7 = 8'h82;
      4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;
      4'h9: hex7 = 8'h90;
      4'hA: hex7 = 8'h88;
      4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;
      4'hD: hex7 = 8'hA1;
      4'hE: hex7 = 8'h86;
      default: hex7 = 8'h8E;
    endcase
  endfunction

  always_comb begin
    sel_ok   = (32'(ch_sel) < 32'(NCH));
    sel_data = '0;
    for (int c = 0; c < NCH; c++) begin
      if (32'(ch_sel) == 32'(c)) sel_data = data_in[c*W +: W];
    end
  end

  // nz_from[i] is set when any nibble at index >= i is non-zero.
  always_comb begin
    nz_from = '0;
    nz_run  = 1'b0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      nz_run     = nz_run | (|hold[4*i +: 4]);
      nz_from[i] = nz_run;
    end
  end

  // Shared decode; blank_lz and dp_mask are applied live, not captured with hold.
  always_comb begin
    dec_flat = '1;
    glyph    = 8'hFF;
    for (int i = 0; i < NDIGITS; i++) begin
      if (blank_lz && (i > 0) && !nz_from[i]) glyph = 8'hFF;
      else                                    glyph = hex7(hold[4*i +: 4]);
      dec_flat[8*i +: 8] = {glyph[7] & ~dp_mask[i], glyph[6:0]};
    end
  end

  assign div_wrap = (div == DIVW'(SCAN_DIV - 1));
  assign idx_last = (idx == IDXW'(NDIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold    <= '0;
      sel_err <= 1'b0;
    end else begin
      sel_err <= 1'b0;
      if (load && !freeze) begin
        if (sel_ok) hold    <= sel_data;
        else        sel_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div        <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= div_wrap && idx_last;
      if (div_wrap) begin
        div <= '0;
        idx <= idx_last ? '0 : idx + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  // Output registers: an/seg_scan follow idx by one cycle, so each digit still dwells SCAN_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_all  <= '1;
      seg_scan <= 8'hFF;
      an       <= '1;
    end else begin
      seg_all  <= dec_flat;
      seg_scan <= dec_flat[{idx, 3'b000} +: 8];
      an       <= ~(NDIGITS'(1) << idx);
    end
  end

endmodule
